branch_redirect_controller: RTL

Sequences control-flow recovery for the pipeline. It takes resolved branch and jump outcomes from the Computational stage and compares them against the direction predicted at fetch. On a mispredict it flushes younger stages and hands a corrected PC to fetch over a valid/ready handshake. It also owns the 2-bit branch history table (BHT) queried by fetch and keeps branch and mispredict performance counters.

---
 rtl/branch_redirect_controller.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/branch_redirect_controller.sv
// ============================================================================
// Module   : branch_redirect_controller
// Purpose  : Mispredict detection, flush/redirect sequencing, 2-bit BHT and
//            branch/mispredict counters. BHT present only with BRANCH_PREDICT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_redirect_controller #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] FetchPC_I,
    output logic            PredTaken_I,
    input  logic            BranchValid_C,
    input  logic            JumpValid_C,
    input  logic            BranchTaken_C,
    input  logic            PredTaken_C,
    input  logic [XLEN-1:0] BranchPC_C,
    input  logic [XLEN-1:0] BranchTarget_C,
    output logic            FlushD,
    output logic            FlushC,
    output logic            StallC,
    output logic            RedirectValid_I,
    output logic [XLEN-1:0] RedirectPC_I,
    input  logic            RedirectReady_I,
    output logic [31:0]     BranchCount,
    output logic [31:0]     MispredictCount
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_redirect_pc;
    logic [31:0]     r_branch_cnt;
    logic [31:0]     r_mispred_cnt;

    logic            w_res;
    logic            w_taken;
    logic            w_mispredict;
    logic            w_idle;
    logic            w_accept;
    logic            w_launch;
    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_corr_pc;

    assign w_res        = BranchValid_C | JumpValid_C;
    assign w_taken      = JumpValid_C | BranchTaken_C;
    assign w_mispredict = w_res & (w_taken != PredTaken_C);
    assign w_idle       = (r_state == ST_IDLE);
    assign w_accept     = w_idle & w_res;
    assign w_launch     = w_idle & w_mispredict;
    assign w_seq_pc     = BranchPC_C + {{(XLEN-3){1'b0}}, 3'b100};
    assign w_corr_pc    = w_taken ? BranchTarget_C : w_seq_pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        FlushD       = 1'b0;
        FlushC       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_mispredict) begin
                    FlushD       = 1'b1;
                    FlushC       = 1'b1;
                    w_state_next = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                if (RedirectReady_I) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Valid/stall decode straight from the state flop so an async reset drops them at once
    assign RedirectValid_I = (r_state == ST_REDIRECT);
    assign StallC          = (r_state == ST_REDIRECT);
    assign RedirectPC_I    = r_redirect_pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_redirect_pc <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_launch) begin
                r_redirect_pc <= w_corr_pc;
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
            if (w_accept) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
        end
    end

    assign BranchCount     = r_branch_cnt;
    assign MispredictCount = r_mispred_cnt;

`ifdef BRANCH_PREDICT_EN
    localparam int c_IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]         r_bht [BHT_ENTRIES];
    logic [c_IDX_W-1:0] w_rd_idx;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [1:0]         w_cur;
    logic [1:0]         w_upd;
    logic               w_bht_we;
    logic               w_unused_fetch;

    assign w_rd_idx       = FetchPC_I[c_IDX_W+1:2];
    assign w_wr_idx       = BranchPC_C[c_IDX_W+1:2];
    assign w_cur          = r_bht[w_wr_idx];
    assign w_bht_we       = w_idle & BranchValid_C;
    assign w_unused_fetch = ^{FetchPC_I[XLEN-1:c_IDX_W+2], FetchPC_I[1:0]};

    always_comb begin
        w_upd = w_cur;
        if (w_taken) begin
            if (w_cur != 2'b11) w_upd = w_cur + 2'b01;
        end else begin
            if (w_cur != 2'b00) w_upd = w_cur - 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_bht_we) begin
            r_bht[w_wr_idx] <= w_upd;
        end
    end

    // Array read reflects pre-update contents when read and write hit the same entry
    assign PredTaken_I = r_bht[w_rd_idx][1];
`else
    logic w_unused_fetch;

    assign w_unused_fetch = ^FetchPC_I;
    assign PredTaken_I    = 1'b0;
`endif

endmodule

`default_nettype wire
